// File: rtl/alu_seq.sv
// Sequencing front end for the combinational alu: buffers commands in a FIFO,
// drives each one to the alu for a full clock, then returns result/flags.
module alu_seq #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic [2:0]   cmd_s,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_s,
  input  logic [W-1:0] alu_r,
  input  logic         alu_c,
  input  logic         alu_v,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_r,
  output logic         rsp_c,
  output logic         rsp_v,
  output logic [2:0]   rsp_s,
  output logic         rsp_err,
  output logic         busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]   state;
  logic [W-1:0] mem_a [DEPTH];
  logic [W-1:0] mem_b [DEPTH];
  logic [2:0]   mem_s [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         full, empty, push, pop, reserved;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = !empty && ((state == IDLE) || ((state == RESP) && rsp_ready));
  assign reserved  = alu_s[2] && alu_s[1];

  assign rsp_valid = (state == RESP);
  assign busy      = !empty || (state != IDLE);

  // NOTE: the storage array has no reset; emptiness is defined by the pointers
  // alone, so stale entries are never observable and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr[AW-1:0]] <= cmd_a;
      mem_b[wr_ptr[AW-1:0]] <= cmd_b;
      mem_s[wr_ptr[AW-1:0]] <= cmd_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Operand register feeds the alu directly and holds its value outside DRIVE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a <= '0;
      alu_b <= '0;
      alu_s <= '0;
    end else if (pop) begin
      alu_a <= mem_a[rd_ptr[AW-1:0]];
      alu_b <= mem_b[rd_ptr[AW-1:0]];
      alu_s <= mem_s[rd_ptr[AW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rsp_r   <= '0;
      rsp_c   <= 1'b0;
      rsp_v   <= 1'b0;
      rsp_s   <= '0;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) state <= DRIVE;
        end
        DRIVE: begin
          state   <= RESP;
          rsp_s   <= alu_s;
          rsp_err <= reserved;
          rsp_r   <= reserved ? '0 : alu_r;
          rsp_c   <= reserved ? 1'b0 : alu_c;
          rsp_v   <= reserved ? 1'b0 : alu_v;
        end
        RESP: begin
          if (rsp_ready) state <= pop ? DRIVE : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: behavioural alu stub, directed scenarios,
// and a randomized stream compared against a queue-based reference model.
module tb_alu_seq;
  localparam int W     = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic [2:0]   s;
    logic         err;
  } rsp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready;
  logic [W-1:0] cmd_a, cmd_b;
  logic [2:0]   cmd_s;
  logic [W-1:0] alu_a, alu_b, alu_r;
  logic [2:0]   alu_s;
  logic         alu_c, alu_v;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_r;
  logic         rsp_c, rsp_v, rsp_err, busy;
  logic [2:0]   rsp_s;
  logic         flag_en;

  int   pass_cnt  = 0;
  int   fail_cnt  = 0;
  int   total_cnt = 0;
  rsp_t exp_q[$];

  always #5 clk = ~clk;

  alu_seq #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_s(cmd_s),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_r(alu_r), .alu_c(alu_c), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_r(rsp_r), .rsp_c(rsp_c), .rsp_v(rsp_v),
    .rsp_s(rsp_s), .rsp_err(rsp_err), .busy(busy)
  );

  // alu stand-in; reserved opcodes produce junk the DUT must discard, and
  // flag_en makes flags data-dependent so pass-through is observable.
  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (alu_s)
      3'd0: alu_r = alu_a & alu_b;
      3'd1: alu_r = alu_a | alu_b;
      3'd2: alu_r = alu_a ^ alu_b;
      3'd3: alu_r = ~alu_a;
      3'd4: alu_r = alu_a;
      3'd5: alu_r = (alu_a == '0) ? W'(1) : W'(0);
      default: alu_r = '1;
    endcase
    if (alu_s >= 3'd6) begin
      alu_c = 1'b1;
      alu_v = 1'b1;
    end else if (flag_en) begin
      alu_c = alu_a[0] ^ alu_b[W-1];
      alu_v = ^alu_b;
    end
  end

  function automatic rsp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] s, input logic fe);
    rsp_t m;
    m.s   = s;
    m.err = 1'b0;
    m.c   = fe ? (a[0] ^ b[W-1]) : 1'b0;
    m.v   = fe ? (^b) : 1'b0;
    case (s)
      3'd0: m.r = a & b;
      3'd1: m.r = a | b;
      3'd2: m.r = a ^ b;
      3'd3: m.r = W'((2 ** W) - 1 - int'(a));
      3'd4: m.r = a;
      3'd5: m.r = (a == '0) ? W'(1) : W'(0);
      default: begin
        m.r   = '0;
        m.c   = 1'b0;
        m.v   = 1'b0;
        m.err = 1'b1;
      end
    endcase
    return m;
  endfunction

  function automatic rsp_t cur_rsp();
    rsp_t m;
    m.r = rsp_r; m.c = rsp_c; m.v = rsp_v; m.s = rsp_s; m.err = rsp_err;
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s);
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_s = s;
  endtask

  // One command into an idle DUT with rsp_ready=1; checks accept+2 latency.
  task automatic send_idle(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] s, input logic [W-1:0] want_r, input logic want_err);
    rsp_t m;
    m = model(a, b, s, flag_en);
    set_cmd(a, b, s);
    check({tag, "_ready"}, cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_v_e0"}, rsp_valid, 0);
    tick();
    check({tag, "_v_e1"}, rsp_valid, 0);
    check({tag, "_drive"}, {alu_a, alu_b, alu_s}, {a, b, s});
    tick();
    check({tag, "_v_e2"}, rsp_valid, 1);
    check({tag, "_r"}, rsp_r, want_r);
    check({tag, "_err"}, rsp_err, want_err);
    check({tag, "_s"}, rsp_s, s);
    check({tag, "_cv"}, {rsp_c, rsp_v}, {m.c, m.v});
    tick();
    check({tag, "_done_v"}, rsp_valid, 0);
    check({tag, "_done_busy"}, busy, 0);
  endtask

  initial begin
    logic [W-1:0] ba [6];
    logic [W-1:0] bb [6];
    logic [2:0]   bs [6];
    int sent, got, cyc;

    rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_s = '0;
    rsp_ready = 1'b0; flag_en = 1'b0;
    tick();
    check("rst_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_alu", {alu_a, alu_b, alu_s}, 0);
    rst = 1'b0;
    tick();
    check("rst_ready", cmd_ready, 1);

    // Basic operations and reserved opcodes
    rsp_ready = 1'b1;
    send_idle("and", 4'ha, 4'h5, 3'd0, 4'h0, 1'b0);
    send_idle("or",  4'ha, 4'h5, 3'd1, 4'hf, 1'b0);
    send_idle("xor", 4'hf, 4'hf, 3'd2, 4'h0, 1'b0);
    send_idle("not", 4'h0, 4'h3, 3'd3, 4'hf, 1'b0);
    send_idle("tst0", 4'h0, 4'h9, 3'd5, 4'h1, 1'b0);
    send_idle("tsta", 4'ha, 4'h0, 3'd5, 4'h0, 1'b0);
    send_idle("rsv6", 4'hf, 4'hf, 3'd6, 4'h0, 1'b1);
    send_idle("xfer", 4'ha, 4'h6, 3'd4, 4'ha, 1'b0);
    send_idle("rsv7", 4'h3, 4'hc, 3'd7, 4'h0, 1'b1);

    // Backpressure: fill the FIFO behind a stalled response
    flag_en = 1'b1;
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ba[i] = W'($urandom()) | W'(1);
      bb[i] = W'($urandom());
      bs[i] = 3'($urandom_range(0, 5));
      exp_q.push_back(model(ba[i], bb[i], bs[i], 1'b1));
    end
    for (int i = 0; i < 5; i++) begin
      set_cmd(ba[i], bb[i], bs[i]);
      check("bp_ready", cmd_ready, 1);
      tick();
    end
    set_cmd(ba[5], bb[5], bs[5]);
    for (int i = 0; i < 3; i++) begin
      check("bp_full", cmd_ready, 0);
      check("bp_hold_v", rsp_valid, 1);
      check("bp_hold_rsp", cur_rsp(), exp_q[0]);
      tick();
    end
    rsp_ready = 1'b1;
    void'(exp_q.pop_front());
    tick();
    check("bp_reready", cmd_ready, 1);
    check("bp_gap_v", rsp_valid, 0);
    tick();
    cmd_valid = 1'b0;
    for (int k = 1; k < 6; k++) begin
      if (k > 1) begin
        tick();
        check("bp_gap_v", rsp_valid, 0);
        tick();
      end
      check("bp_v", rsp_valid, 1);
      check("bp_rsp", cur_rsp(), exp_q.pop_front());
    end
    tick();
    check("bp_drained", {busy, rsp_valid}, 0);

    // Reset mid-stream: one response pending plus three queued commands
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_cmd(4'h9 + W'(i), 4'h6, 3'd4);
      tick();
    end
    cmd_valid = 1'b0;
    tick();
    check("mid_v", rsp_valid, 1);
    check("mid_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", rsp_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_alu", {alu_a, alu_b, alu_s}, 0);
    check("arst_rsp", cur_rsp(), 0);
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    check("arst_ready", cmd_ready, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("arst_stale", {rsp_valid, busy}, 0);
    end

    // Randomized stream across several pointer wraps
    sent = 0; got = 0; cyc = 0;
    while (got < 20 && cyc < 2000) begin
      cmd_valid = (sent < 20) && ($urandom_range(0, 3) != 0);
      cmd_a = W'($urandom());
      cmd_b = W'($urandom());
      cmd_s = 3'($urandom_range(0, 5));
      rsp_ready = ($urandom_range(0, 2) != 0);
      check("rnd_busy", busy, (exp_q.size() != 0));
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rnd_spurious", rsp_valid, 0);
        end else begin
          check("rnd_rsp", cur_rsp(), exp_q[0]);
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            got++;
          end
        end
      end
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back(model(cmd_a, cmd_b, cmd_s, 1'b1));
        sent++;
      end
      tick();
      cyc++;
    end
    cmd_valid = 1'b0;
    check("rnd_count", got, 20);
    tick();
    check("rnd_drained", {busy, rsp_valid}, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
